// File: rtl/spi_tx_control.sv
// SPI command handler for the coax transmit path: turns (hi, lo) byte pairs into 10-bit TX FIFO words.
// Optional: define SPI_TX_CONTROL_AUTO_START_EN to pulse tx_start early once AUTO_START_THRESHOLD words are queued.
module spi_tx_control #(
  parameter int COUNT_WIDTH          = 8,
  parameter int AUTO_START_THRESHOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic [7:0] spi_rx_data,
  input  logic       spi_rx_strobe,
  output logic [7:0] spi_tx_data,
  output logic       spi_tx_strobe,
  output logic [9:0] tx_data,
  output logic       tx_load_strobe,
  input  logic       tx_full,
  input  logic       tx_empty,
  input  logic       tx_active,
  output logic       tx_start
);

  // state   | meaning
  // IDLE    | waiting for a 0x?4 command byte
  // STATUS  | one cycle: queue the FIFO status reply
  // HI      | waiting for the high byte of a pair
  // LO      | waiting for the low byte; completes and writes the word
  // DISCARD | protocol error seen, ignore bytes until deselect
  typedef enum logic [2:0] {
    S_IDLE,
    S_STATUS,
    S_HI,
    S_LO,
    S_DISCARD
  } state_t;

`ifdef SPI_TX_CONTROL_AUTO_START_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam logic [COUNT_WIDTH-1:0] AUTO_THRESH = COUNT_WIDTH'(AUTO_START_THRESHOLD);

  state_t                 state;
  logic [1:0]             hi;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;
  logic                   proto_err;
  logic                   started;

  logic [COUNT_WIDTH-1:0] count_inc;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   overflow_next;
  logic                   cs_start;
  logic                   auto_start;

  always_comb begin
    count_inc     = (&count) ? count : count + 1'b1;
    count_next    = tx_full ? count : count_inc;
    overflow_next = overflow | tx_full;
    // Only a frame that was mid-pair or between pairs can start; DISCARD never does.
    cs_start      = ((state == S_HI) || (state == S_LO)) && (count != '0) &&
                    !proto_err && !started;
    auto_start    = AUTO_EN && !tx_full && (count_inc == AUTO_THRESH) && !started;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      hi             <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      proto_err      <= 1'b0;
      started        <= 1'b0;
      spi_tx_data    <= '0;
      spi_tx_strobe  <= 1'b0;
      tx_data        <= '0;
      tx_load_strobe <= 1'b0;
      tx_start       <= 1'b0;
    end else begin
      spi_tx_strobe  <= 1'b0;
      tx_load_strobe <= 1'b0;
      tx_start       <= 1'b0;
      if (spi_cs) begin
        // Deselect overrides everything; a pending hi byte is simply dropped.
        state <= S_IDLE;
        if (cs_start) begin
          tx_start <= 1'b1;
          started  <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (spi_rx_strobe && (spi_rx_data[3:0] == 4'h4)) begin
              overflow  <= 1'b0;
              proto_err <= 1'b0;
              count     <= '0;
              started   <= 1'b0;
              state     <= S_STATUS;
            end
          end
          S_STATUS: begin
            spi_tx_data   <= {tx_active, tx_full, tx_empty, 5'b0};
            spi_tx_strobe <= 1'b1;
            state         <= S_HI;
          end
          S_HI: begin
            if (spi_rx_strobe) begin
              if (|spi_rx_data[7:2]) begin
                proto_err <= 1'b1;
                state     <= S_DISCARD;
              end else begin
                hi    <= spi_rx_data[1:0];
                state <= S_LO;
              end
            end
          end
          S_LO: begin
            if (spi_rx_strobe) begin
              if (tx_full) begin
                overflow <= 1'b1;
              end else begin
                tx_data        <= {hi, spi_rx_data};
                tx_load_strobe <= 1'b1;
                count          <= count_inc;
                if (auto_start) begin
                  tx_start <= 1'b1;
                  started  <= 1'b1;
                end
              end
              spi_tx_data   <= {overflow_next, proto_err, count_next[5:0]};
              spi_tx_strobe <= 1'b1;
              state         <= S_HI;
            end
          end
          S_DISCARD: state <= S_DISCARD;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_control.sv
// Directed self-checking bench for spi_tx_control; builds with or without SPI_TX_CONTROL_AUTO_START_EN.
module tb_spi_tx_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs;
  logic [7:0] spi_rx_data;
  logic       spi_rx_strobe;
  logic [7:0] spi_tx_data;
  logic       spi_tx_strobe;
  logic [9:0] tx_data;
  logic       tx_load_strobe;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_active;
  logic       tx_start;

  always #5 clk = ~clk;

  spi_tx_control #(.COUNT_WIDTH(8), .AUTO_START_THRESHOLD(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .spi_cs         (spi_cs),
    .spi_rx_data    (spi_rx_data),
    .spi_rx_strobe  (spi_rx_strobe),
    .spi_tx_data    (spi_tx_data),
    .spi_tx_strobe  (spi_tx_strobe),
    .tx_data        (tx_data),
    .tx_load_strobe (tx_load_strobe),
    .tx_full        (tx_full),
    .tx_empty       (tx_empty),
    .tx_active      (tx_active),
    .tx_start       (tx_start)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] word_q[$];
  logic [7:0] reply_q[$];
  int         start_cnt = 0;
  int         co_cnt    = 0;
  int         co_idx    = 0;

  // Output monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (spi_tx_strobe) reply_q.push_back(spi_tx_data);
    if (tx_load_strobe) word_q.push_back(tx_data);
    if (tx_start) begin
      start_cnt++;
      if (tx_load_strobe) begin
        co_cnt++;
        co_idx = word_q.size();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    spi_rx_data   = b;
    spi_rx_strobe = 1'b1;
    tick();
    spi_rx_strobe = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_mon();
    word_q.delete();
    reply_q.delete();
    start_cnt = 0;
    co_cnt    = 0;
    co_idx    = 0;
  endtask

  task automatic frame_begin(input logic [7:0] cmd);
    clear_mon();
    spi_cs = 1'b0;
    tick();
    send(cmd);
  endtask

  // Raise cs and check the registered tx_start pulse and that it lasts one cycle.
  task automatic release_cs(input string tag, input logic exp_start);
    spi_cs = 1'b1;
    tick();
    check({tag, "_start"}, tx_start, exp_start);
    tick();
    check({tag, "_start_off"}, tx_start, 1'b0);
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    spi_cs        = 1'b1;
    spi_rx_data   = '0;
    spi_rx_strobe = 1'b0;
    tx_full       = 1'b0;
    tx_empty      = 1'b1;
    tx_active     = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {spi_tx_data, spi_tx_strobe, tx_data, tx_load_strobe, tx_start}, 32'h0);
    reset = 1'b0;
    tick();

    // Basic frame
    frame_begin(8'h04);
    send(8'h02); send(8'h5A); send(8'h01); send(8'h00);
    check("t1_nreply", reply_q.size(), 3);
    check("t1_status", reply_q[0], 8'h20);
    check("t1_reply1", reply_q[1], 8'h01);
    check("t1_reply2", reply_q[2], 8'h02);
    check("t1_nword", word_q.size(), 2);
    check("t1_word0", word_q[0], 10'h25A);
    check("t1_word1", word_q[1], 10'h100);
    check("t1_no_early_start", start_cnt, 0);
    release_cs("t1", 1'b1);
    check("t1_start_cnt", start_cnt, 1);

    // Overflow on the second lo byte
    frame_begin(8'h04);
    send(8'h02); send(8'h5A); send(8'h01);
    tx_full = 1'b1;
    send(8'h00);
    tx_full = 1'b0;
    check("t2_nword", word_q.size(), 1);
    check("t2_nreply", reply_q.size(), 3);
    check("t2_reply1", reply_q[1], 8'h01);
    check("t2_reply2", reply_q[2], 8'h81);
    release_cs("t2", 1'b1);

    // Protocol error
    frame_begin(8'h04);
    send(8'h84); send(8'h01); send(8'h22);
    check("t3_nword", word_q.size(), 0);
    check("t3_nreply", reply_q.size(), 1);
    release_cs("t3", 1'b0);
    check("t3_start_cnt", start_cnt, 0);

    // Partial pair, then a fresh 0x14 command
    frame_begin(8'h04);
    send(8'h02); send(8'h5A); send(8'h03);
    release_cs("t4", 1'b1);
    check("t4_nword", word_q.size(), 1);
    frame_begin(8'h14);
    send(8'h01); send(8'h00);
    check("t4_nreply", reply_q.size(), 2);
    check("t4_reply1", reply_q[1], 8'h01);
    check("t4_word0", word_q[0], 10'h100);
    release_cs("t4b", 1'b1);

    // Reset mid-frame while in LO
    frame_begin(8'h04);
    send(8'h02);
    reset = 1'b1;
    tick();
    check("t5_rst_outputs", {spi_tx_data, spi_tx_strobe, tx_data, tx_load_strobe, tx_start}, 32'h0);
    reset  = 1'b0;
    spi_cs = 1'b1;
    tick();
    check("t5_no_start", tx_start, 1'b0);
    tick();
    clear_mon();
    spi_cs = 1'b0;
    tick();
    send(8'h02); send(8'h5A);
    check("t5_ignored_reply", reply_q.size(), 0);
    check("t5_ignored_word", word_q.size(), 0);
    send(8'h34);
    check("t5_cmd_reply_n", reply_q.size(), 1);
    check("t5_cmd_reply", reply_q[0], 8'h20);
    spi_cs = 1'b1;
    tick(); tick();
    check("t5_start_cnt", start_cnt, 0);

    // Three pairs while the transmitter is busy
    tx_active = 1'b1;
    tx_empty  = 1'b0;
    frame_begin(8'h04);
    send(8'h00); send(8'h11);
    send(8'h00); send(8'h22);
    send(8'h00); send(8'h33);
    check("t6_status", reply_q[0], 8'h80);
    check("t6_reply3", reply_q[3], 8'h03);
    check("t6_nword", word_q.size(), 3);
    check("t6_word2", word_q[2], 10'h033);
`ifdef SPI_TX_CONTROL_AUTO_START_EN
    check("t6_auto_start_cnt", start_cnt, 1);
    check("t6_auto_coincide", co_cnt, 1);
    check("t6_auto_idx", co_idx, 2);
    release_cs("t6", 1'b0);
    check("t6_total_start", start_cnt, 1);
`else
    check("t6_no_early_start", start_cnt, 0);
    release_cs("t6", 1'b1);
    check("t6_total_start", start_cnt, 1);
`endif
    tx_active = 1'b0;
    tx_empty  = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_control.md
Name: spi_tx_control

Overview:
- SPI command handler for the coax transmit path, the counterpart to the receive-side read handler.
- The host selects SPI, sends command 0x?4, then byte pairs (hi, lo). Each pair becomes one 10-bit coax word written into the TX FIFO.
- Releasing spi_cs ends the frame and starts transmission of the queued words.
- Sits between the SPI slave byte interface and the TX FIFO / coax transmitter.

Parameters:
- COUNT_WIDTH, 8: width of the per-frame word counter; saturates at all-ones.
- AUTO_START_THRESHOLD, 8: word count that triggers an early tx_start; used only with SPI_TX_CONTROL_AUTO_START_EN.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- spi_cs  in  1  high = SPI deselected; forces IDLE
- spi_rx_data  in  8  received SPI byte
- spi_rx_strobe  in  1  one-cycle pulse, spi_rx_data valid
- spi_tx_data  out  8  byte for next SPI exchange
- spi_tx_strobe  out  1  one-cycle pulse, load spi_tx_data
- tx_data  out  10  word to TX FIFO
- tx_load_strobe  out  1  one-cycle FIFO write
- tx_full  in  1  TX FIFO full
- tx_empty  in  1  TX FIFO empty
- tx_active  in  1  transmitter busy
- tx_start  out  1  one-cycle pulse, begin transmission

Behaviour:
- Output timing: all outputs are registered; next values are computed combinationally from state and inputs.
- Reset: every output is 0; state is IDLE; internal flags, counter and hi register are 0. Reset wins over all other events, including mid-frame; no tx_start is issued.
- IDLE:
  - On spi_rx_strobe with spi_rx_data[3:0]==4'h4: clear overflow, proto_err and count; go to STATUS.
  - Any other byte is ignored.
- STATUS (one cycle):
  - spi_tx_data <= {tx_active, tx_full, tx_empty, 5'b0}; spi_tx_strobe <= 1.
  - Go to HI.
  - Latency: command strobe at cycle N gives spi_tx_strobe high at cycle N+2.
- HI, on spi_rx_strobe:
  - If spi_rx_data[7:2]!=0: set proto_err and go to DISCARD.
  - Otherwise store spi_rx_data[1:0] as hi and go to LO.
- LO, on spi_rx_strobe:
  - Word = {hi, spi_rx_data}.
  - If tx_full: set overflow and drop the word (no write, count unchanged).
  - Otherwise: tx_data <= word, tx_load_strobe <= 1, count <= count+1, saturating.
  - In the same cycle: spi_tx_data <= {overflow_next, proto_err, count_next[5:0]}; spi_tx_strobe <= 1.
  - Go to HI.
- DISCARD: ignores all bytes until spi_cs goes high. No FIFO writes, no SPI replies.
- spi_cs high, any state: next state is IDLE; this overrides the state's own transition.
- tx_start <= 1 for one cycle on the first cycle spi_cs is high, only if:
  - state was HI or LO, and
  - count>0, and
  - proto_err==0, and
  - no start has yet been issued this frame.
- Partial pair: if spi_cs goes high while in LO, the hi byte is discarded and does not count.
- Writes while tx_active=1 are accepted; the FIFO queues behind the current transmission.
- tx_start is issued regardless of tx_active; the transmitter ignores it when busy.
- Simultaneous spi_rx_strobe and spi_cs high: spi_cs wins; the byte is discarded.
- In IDLE: a byte with low nibble other than 4 is a no-op; no reply is generated.

Optional Feature:
- Macro: SPI_TX_CONTROL_AUTO_START_EN.
- Defined:
  - When a FIFO write makes count_next==AUTO_START_THRESHOLD, tx_start pulses in the same cycle as tx_load_strobe.
  - The "started" flag is set, so the spi_cs-release start is suppressed for that frame.
  - Further writes continue streaming into the FIFO.
- Undefined: tx_start is issued only on spi_cs release. The AUTO_START_THRESHOLD parameter is unused.

Test Plan:
1. Basic frame:
   - Stimulus: cmd 0x04 with tx_empty=1, tx_active=0; then pairs (0x02,0x5A) and (0x01,0x00); then spi_cs high.
   - Required: status reply 0x20; tx_data 0x25A then 0x100; reply bytes 0x01 and 0x02; exactly one tx_start on the cs-rise cycle.
2. Overflow:
   - Stimulus: tx_full=1 during the second pair's lo byte.
   - Required: only one tx_load_strobe; second reply 0x81; tx_start still pulses at cs release (count=1).
3. Protocol error:
   - Stimulus: hi byte 0x84.
   - Required: no tx_load_strobe; subsequent bytes ignored with no replies; no tx_start on cs release.
4. Partial pair:
   - Stimulus: cmd, one full pair, then hi byte 0x03, then spi_cs high.
   - Required: exactly one write; tx_start pulses; a new cmd 0x14 clears flags and the first reply after the next pair is 0x01.
5. Reset mid-frame:
   - Stimulus: assert reset while in LO.
   - Required: all outputs 0 the next cycle; state IDLE; no tx_start at the later cs release; bytes other than a new command are ignored.
6. Auto start (macro defined, AUTO_START_THRESHOLD=2):
   - Stimulus: 3 pairs, then cs release.
   - Required: tx_start coincident with the 2nd tx_load_strobe; the 3rd word is still written; no second tx_start at cs release.
